fetch_instr_queue: RTL and testbench
====================================

# fetch_instr_queue

Multi-lane, parametrised instruction queue between the I-cache/branch-predictor fetch stage and decode. It replaces the single-lane instruction FIFO. Each entry carries the instruction, its PC, the predicted-taken bit and the predicted target PC. Up to ENQ_LANES entries are accepted and up to DEQ_LANES entries are delivered per cycle, with a one-cycle flush for mispredict/redirect recovery.

## Interface
- FIFO_DEPTH, 8: number of entries; power of two, ≥ max(ENQ_LANES, DEQ_LANES), ≥ 4.
- ENQ_LANES, 2: fetch lanes written per cycle, 1..4.
- DEQ_LANES, 2: decode lanes read per cycle, 1..4.
- INSTR_WIDTH, 32: instruction bits.
- ADDR_WIDTH, 32: PC and target-PC bits.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_aL  in  1  asynchronous, active-low reset.
- flush  in  1  discard all contents at the next edge.
- valid_enq  in  ENQ_LANES  per-lane enqueue valid; lane 0 is oldest.
- data_enq  in  ENQ_LANES×ENTRY_WIDTH  packed entries {instr, pc, pred_taken, tgt_pc}.
- ready_enq  out  1  queue can take ENQ_LANES entries this cycle.
- valid_deq  out  DEQ_LANES  per-lane dequeue valid; lane 0 is oldest.
- data_deq  out  DEQ_LANES×ENTRY_WIDTH  head entries in order.
- ready_deq  in  DEQ_LANES  per-lane consumer accept.
- occupancy  out  $clog2(FIFO_DEPTH+1)  current entry count.

## Operation
- Storage: FIFO_DEPTH-entry circular array, rd_ptr and wr_ptr of $clog2(FIFO_DEPTH) bits wrapping modulo FIFO_DEPTH, separate count register.
- ready_enq = (FIFO_DEPTH − count) ≥ ENQ_LANES. It depends on registered count only, never on this cycle's dequeue.
- Enqueue count n_enq = length of the contiguous run of 1s in valid_enq starting at lane 0. Lanes after the first 0 are ignored. n_enq = 0 when ready_enq = 0.
- Accepted lane i is written to array[wr_ptr+i]; wr_ptr advances by n_enq.
- valid_deq[j] = (count > j); data_deq[j] = array[rd_ptr+j]. Invalid lanes' data are don't-care.
- Dequeue count n_deq = length of the contiguous run starting at lane 0 where valid_deq & ready_deq. rd_ptr advances by n_deq.
- count_next = count + n_enq − n_deq. Simultaneous enqueue and dequeue are both honoured; ready_enq guarantees no overflow.
- flush = 1: rd_ptr, wr_ptr and count go to 0 at the edge. Same-cycle enqueue and dequeue are discarded. Flush has priority over all other activity.
- Array contents are not reset. Only pointers and count are reset.

## Timing
- Reset (rst_aL low, asynchronous): rd_ptr = wr_ptr = count = 0. Resulting outputs: valid_deq = 0, ready_enq = 1, occupancy = 0. Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Enqueue-to-dequeue latency is 1 cycle: an entry written at edge N is visible on data_deq after edge N. There is no same-cycle bypass when the queue is empty.
- All outputs are functions of registered state only; there is no combinational path from any input to any output.
- The cycle after a flush: valid_deq = 0, occupancy = 0, ready_enq = 1.
- Full (count = FIFO_DEPTH): ready_enq = 0, all valid_deq lanes are 1. Empty: valid_deq = 0.
- Wrap-around: a multi-lane access that straddles index FIFO_DEPTH−1 → 0 must write and read correctly within the same cycle.

## Structure
- Shared package fetch_pkg holds:
  - INSTR_WIDTH and ADDR_WIDTH.
  - A fetch_entry_t struct {instr, pc, pred_taken, tgt_pc}.
  - ENTRY_WIDTH = INSTR_WIDTH + 2·ADDR_WIDTH + 1.
- One sub-module, prefix_count: parametrised width, outputs the length of the leading run of 1s. It is instantiated once for enqueue and once for dequeue.

## Test plan
- Fill/drain: DEPTH=8, ENQ=2, push 2 per cycle with ready_deq=0. After 4 edges occupancy=8 and ready_enq=0. Then ready_deq=2'b11 drains in 4 cycles, in order, with PCs matching.
- Simultaneous: occupancy=3, enqueue 2 and dequeue 2 in the same cycle → occupancy stays 3, order preserved, ready_enq remains 1.
- Non-contiguous lanes: valid_enq=2'b10 → nothing enqueued. ready_deq=2'b10 with 2 valid → nothing dequeued.
- Wrap: with rd_ptr=wr_ptr=7 and empty, enqueue 2 entries → they land at slots 7 and 0. Dequeue returns them in order with pred_taken and tgt_pc intact.
- Flush: occupancy=5, flush=1 together with valid_enq=2'b11 and ready_deq=2'b11 → next cycle occupancy=0, valid_deq=0, ready_enq=1, and no stale entry is ever delivered.
- Async reset mid-stream: drop rst_aL between clock edges with occupancy=6 → valid_deq=0 and occupancy=0 immediately. After release, normal enqueue resumes on the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and widths for the fetch-to-decode instruction queue.
//   INSTR_WIDTH / ADDR_WIDTH : default instruction and PC widths
//   fetch_entry_t            : one queue entry {instr, pc, pred_taken, tgt_pc}
//   ENTRY_WIDTH              : packed width of fetch_entry_t
package fetch_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned ENTRY_WIDTH = INSTR_WIDTH + 2 * ADDR_WIDTH + 1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   pred_taken;
    logic [ADDR_WIDTH-1:0]  tgt_pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_instr_queue_prefix_count.sv
// prefix_count: length of the run of 1s starting at bit 0.
//   bits  in  WIDTH               input vector, bit 0 first
//   count out $clog2(WIDTH+1)     number of consecutive 1s from bit 0
module prefix_count #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0]         bits,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  logic run;

  always_comb begin
    count = '0;
    run   = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      run = run & bits[i];
      if (run) begin
        count = count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue: multi-lane circular instruction queue between fetch and decode.
//   clk        in   sole clock, rising edge
//   rst_aL     in   asynchronous active-low reset (pointers and count only)
//   flush      in   drop all contents at the next edge; beats same-cycle enq/deq
//   valid_enq  in   per-lane enqueue valid, lane 0 oldest
//   data_enq   in   packed entries, lane i at [i*ENTRY_W +: ENTRY_W]
//   ready_enq  out  room for ENQ_LANES entries (from registered count only)
//   valid_deq  out  per-lane dequeue valid, lane 0 oldest
//   data_deq   out  head entries in order, lane j at [j*ENTRY_W +: ENTRY_W]
//   ready_deq  in   per-lane consumer accept
//   occupancy  out  current entry count
module fetch_instr_queue
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ENQ_LANES   = 2,
  parameter int unsigned DEQ_LANES   = 2,
  parameter int unsigned INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
  parameter int unsigned ADDR_WIDTH  = fetch_pkg::ADDR_WIDTH
) (
  input  logic                                                 clk,
  input  logic                                                 rst_aL,
  input  logic                                                 flush,
  input  logic [ENQ_LANES-1:0]                                 valid_enq,
  input  logic [ENQ_LANES*(INSTR_WIDTH+2*ADDR_WIDTH+1)-1:0]    data_enq,
  output logic                                                 ready_enq,
  output logic [DEQ_LANES-1:0]                                 valid_deq,
  output logic [DEQ_LANES*(INSTR_WIDTH+2*ADDR_WIDTH+1)-1:0]    data_deq,
  input  logic [DEQ_LANES-1:0]                                 ready_deq,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]                      occupancy
);

  localparam int unsigned ENTRY_W = INSTR_WIDTH + 2 * ADDR_WIDTH + 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EC_W    = $clog2(ENQ_LANES + 1);
  localparam int unsigned DC_W    = $clog2(DEQ_LANES + 1);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [EC_W-1:0]      enq_run;
  logic [EC_W-1:0]      n_enq;
  logic [DEQ_LANES-1:0] deq_fire;
  logic [DC_W-1:0]      n_deq;

  prefix_count #(.WIDTH(ENQ_LANES)) u_enq_count (
    .bits  (valid_enq),
    .count (enq_run)
  );

  prefix_count #(.WIDTH(DEQ_LANES)) u_deq_count (
    .bits  (deq_fire),
    .count (n_deq)
  );

  always_comb begin
    ready_enq = (CNT_W'(FIFO_DEPTH) - count_q) >= CNT_W'(ENQ_LANES);
    occupancy = count_q;
    n_enq     = ready_enq ? enq_run : '0;
  end

  // Pointer arithmetic wraps naturally because FIFO_DEPTH is a power of two,
  // so lanes straddling the last slot land at the start of the array.
  always_comb begin
    valid_deq = '0;
    data_deq  = '0;
    for (int unsigned j = 0; j < DEQ_LANES; j++) begin
      valid_deq[j]                = count_q > CNT_W'(j);
      data_deq[j*ENTRY_W +: ENTRY_W] = mem_q[rd_ptr_q + PTR_W'(j)];
    end
    deq_fire = valid_deq & ready_deq;
  end

  always_comb begin
    mem_d = mem_q;
    if (!flush) begin
      for (int unsigned i = 0; i < ENQ_LANES; i++) begin
        if (EC_W'(i) < n_enq) begin
          mem_d[wr_ptr_q + PTR_W'(i)] = data_enq[i*ENTRY_W +: ENTRY_W];
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(n_deq);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
    count_d  = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; count gates what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
module tb_fetch_instr_queue;
  import fetch_pkg::*;

  localparam int unsigned EW = ENTRY_WIDTH;

  logic            clk;
  logic            rst_aL;
  logic            flush;
  logic [1:0]      valid_enq;
  logic [2*EW-1:0] data_enq;
  logic            ready_enq;
  logic [1:0]      valid_deq;
  logic [2*EW-1:0] data_deq;
  logic [1:0]      ready_deq;
  logic [3:0]      occupancy;

  int checks = 0;
  int errors = 0;

  fetch_instr_queue #(
    .FIFO_DEPTH (8),
    .ENQ_LANES  (2),
    .DEQ_LANES  (2),
    .INSTR_WIDTH(32),
    .ADDR_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst_aL   (rst_aL),
    .flush    (flush),
    .valid_enq(valid_enq),
    .data_enq (data_enq),
    .ready_enq(ready_enq),
    .valid_deq(valid_deq),
    .data_deq (data_deq),
    .ready_deq(ready_deq),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        flush;
    logic [1:0]  venq;
    logic [1:0]  rdeq;
    logic [31:0] pc0;
    logic [31:0] pc1;
    int          occ;
    logic [31:0] h0;
    logic [31:0] h1;
  } vec_t;

  function automatic fetch_entry_t mk(input logic [31:0] pc);
    fetch_entry_t e;
    e.instr      = pc ^ 32'hA5A5_0000;
    e.pc         = pc;
    e.pred_taken = pc[2];
    e.tgt_pc     = pc + 32'h100;
    return e;
  endfunction

  function automatic vec_t v(input logic fl, input logic [1:0] venq, input logic [1:0] rdeq,
                             input logic [31:0] pc0, input logic [31:0] pc1,
                             input int occ, input logic [31:0] h0, input logic [31:0] h1);
    vec_t r;
    r.flush = fl; r.venq = venq; r.rdeq = rdeq; r.pc0 = pc0; r.pc1 = pc1;
    r.occ = occ; r.h0 = h0; r.h1 = h1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare outputs against an expected occupancy and head PCs.
  task automatic chk_state(input string tag, input int occ, input logic [31:0] h0, input logic [31:0] h1);
    logic [1:0] exp_v;
    exp_v = {occ > 1, occ > 0};
    chk({tag, " occupancy"}, 128'(occupancy), 128'(occ));
    chk({tag, " valid_deq"}, 128'(valid_deq), 128'(exp_v));
    chk({tag, " ready_enq"}, 128'(ready_enq), 128'((8 - occ) >= 2));
    if (occ > 0) chk({tag, " lane0"}, 128'(data_deq[0 +: EW]), 128'(mk(h0)));
    if (occ > 1) chk({tag, " lane1"}, 128'(data_deq[EW +: EW]), 128'(mk(h1)));
  endtask

  task automatic drive(input logic fl, input logic [1:0] venq, input logic [1:0] rdeq,
                       input logic [31:0] pc0, input logic [31:0] pc1);
    flush     = fl;
    valid_enq = venq;
    ready_deq = rdeq;
    data_enq  = {mk(pc1), mk(pc0)};
  endtask

  vec_t vecs [27];

  initial begin
    vecs[0]  = v(0, 2'b11, 2'b00, 32'h100, 32'h104, 2, 32'h100, 32'h104);
    vecs[1]  = v(0, 2'b11, 2'b00, 32'h108, 32'h10C, 4, 32'h100, 32'h104);
    vecs[2]  = v(0, 2'b11, 2'b00, 32'h110, 32'h114, 6, 32'h100, 32'h104);
    vecs[3]  = v(0, 2'b11, 2'b00, 32'h118, 32'h11C, 8, 32'h100, 32'h104);
    vecs[4]  = v(0, 2'b11, 2'b00, 32'h200, 32'h204, 8, 32'h100, 32'h104);
    vecs[5]  = v(0, 2'b00, 2'b11, 32'h0,   32'h0,   6, 32'h108, 32'h10C);
    vecs[6]  = v(0, 2'b00, 2'b11, 32'h0,   32'h0,   4, 32'h110, 32'h114);
    vecs[7]  = v(0, 2'b00, 2'b11, 32'h0,   32'h0,   2, 32'h118, 32'h11C);
    vecs[8]  = v(0, 2'b00, 2'b11, 32'h0,   32'h0,   0, 32'h0,   32'h0);
    vecs[9]  = v(0, 2'b10, 2'b00, 32'h300, 32'h304, 0, 32'h0,   32'h0);
    vecs[10] = v(0, 2'b01, 2'b00, 32'h310, 32'h3FC, 1, 32'h310, 32'h0);
    vecs[11] = v(0, 2'b11, 2'b00, 32'h314, 32'h318, 3, 32'h310, 32'h314);
    vecs[12] = v(0, 2'b00, 2'b10, 32'h0,   32'h0,   3, 32'h310, 32'h314);
    vecs[13] = v(0, 2'b00, 2'b01, 32'h0,   32'h0,   2, 32'h314, 32'h318);
    vecs[14] = v(0, 2'b01, 2'b00, 32'h31C, 32'h0,   3, 32'h314, 32'h318);
    vecs[15] = v(0, 2'b11, 2'b11, 32'h320, 32'h324, 3, 32'h31C, 32'h320);
    vecs[16] = v(0, 2'b01, 2'b01, 32'h328, 32'h0,   3, 32'h320, 32'h324);
    vecs[17] = v(0, 2'b00, 2'b11, 32'h0,   32'h0,   1, 32'h328, 32'h0);
    vecs[18] = v(0, 2'b00, 2'b01, 32'h0,   32'h0,   0, 32'h0,   32'h0);
    // rd_ptr = wr_ptr = 7, empty: next pair straddles slots 7 and 0
    vecs[19] = v(0, 2'b11, 2'b00, 32'h400, 32'h404, 2, 32'h400, 32'h404);
    vecs[20] = v(0, 2'b00, 2'b11, 32'h0,   32'h0,   0, 32'h0,   32'h0);
    vecs[21] = v(0, 2'b11, 2'b00, 32'h500, 32'h504, 2, 32'h500, 32'h504);
    vecs[22] = v(0, 2'b11, 2'b00, 32'h508, 32'h50C, 4, 32'h500, 32'h504);
    vecs[23] = v(0, 2'b01, 2'b00, 32'h510, 32'h0,   5, 32'h500, 32'h504);
    vecs[24] = v(1, 2'b11, 2'b11, 32'h600, 32'h604, 0, 32'h0,   32'h0);
    vecs[25] = v(0, 2'b00, 2'b11, 32'h0,   32'h0,   0, 32'h0,   32'h0);
    vecs[26] = v(0, 2'b01, 2'b00, 32'h700, 32'h0,   1, 32'h700, 32'h0);

    rst_aL = 1'b0;
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0);
    #12;
    chk_state("reset", 0, 32'h0, 32'h0);
    @(negedge clk);
    rst_aL = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].flush, vecs[k].venq, vecs[k].rdeq, vecs[k].pc0, vecs[k].pc1);
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", k), vecs[k].occ, vecs[k].h0, vecs[k].h1);
    end

    // Async reset between edges with six entries held
    drive(0, 2'b11, 2'b00, 32'h710, 32'h714);
    @(posedge clk); #1;
    drive(0, 2'b11, 2'b00, 32'h718, 32'h71C);
    @(posedge clk); #1;
    drive(0, 2'b01, 2'b00, 32'h720, 32'h0);
    @(posedge clk); #1;
    chk_state("prefill", 6, 32'h700, 32'h710);
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0);
    #3;
    rst_aL = 1'b0;
    #1;
    chk_state("async_rst", 0, 32'h0, 32'h0);
    #1;
    rst_aL = 1'b1;
    drive(0, 2'b11, 2'b00, 32'h800, 32'h804);
    @(posedge clk); #1;
    chk_state("post_rst", 2, 32'h800, 32'h804);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
